// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_TIMEOUT  = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;

    localparam logic [1:0] RES_LOAD = 2'b01;

    localparam int TIMEOUT_LIMIT_DEF = 255;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Operand forwarding select for one E-stage source register; M result has priority over W.
module hazard_fwd_unit
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] i_rs,
    input  logic [4:0] i_rd_m,
    input  logic [4:0] i_rd_w,
    input  logic       i_reg_write_m,
    input  logic       i_reg_write_w,
    output logic [1:0] o_fwd
);

    logic w_hit_m;
    logic w_hit_w;

    // x0 is hardwired to zero, so a write to it never produces a forwardable value
    assign w_hit_m = i_reg_write_m && (i_rd_m != 5'd0) && (i_rd_m == i_rs);
    assign w_hit_w = i_reg_write_w && (i_rd_w != 5'd0) && (i_rd_w == i_rs);

    always_comb begin
        o_fwd = FWD_RF;
        if (w_hit_m) begin
            o_fwd = FWD_M;
        end else if (w_hit_w) begin
            o_fwd = FWD_W;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory-wait stalls
// with timeout, operand forwarding and a saturating stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT_LIMIT = TIMEOUT_LIMIT_DEF,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCount
);

    localparam int WAIT_W = (TIMEOUT_LIMIT < 2) ? 1 : $clog2(TIMEOUT_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_LIMIT);

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_timeout;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_mem_stall;
    logic              w_lw_stall;
    logic [WAIT_W-1:0] w_wait_nxt;

    hazard_fwd_unit u_fwd_a (
        .i_rs          (Rs1E),
        .i_rd_m        (RdM),
        .i_rd_w        (RdW),
        .i_reg_write_m (RegWriteM),
        .i_reg_write_w (RegWriteW),
        .o_fwd         (ForwardAE)
    );

    hazard_fwd_unit u_fwd_b (
        .i_rs          (Rs2E),
        .i_rd_m        (RdM),
        .i_rd_w        (RdW),
        .i_reg_write_m (RegWriteM),
        .i_reg_write_w (RegWriteW),
        .o_fwd         (ForwardBE)
    );

    // Once waiting, M is frozen, so only MemReadyM decides whether the stall continues
    always_comb begin
        w_mem_stall = 1'b0;
        case (r_state)
            ST_RUN:      w_mem_stall = MemReqM && !MemReadyM;
            ST_MEM_WAIT: w_mem_stall = !MemReadyM;
            ST_TIMEOUT:  w_mem_stall = 1'b1;
            default:     w_mem_stall = 1'b0;
        endcase
    end

    assign w_lw_stall = (ResultSrcE == RES_LOAD) && (RdE != 5'd0) &&
                        ((RdE == Rs1D) || (RdE == Rs2D));

    assign w_wait_nxt = (r_state == ST_RUN) ? WAIT_W'(1) : r_wait_cnt + WAIT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN, ST_MEM_WAIT: begin
                    if (w_mem_stall) begin
                        r_wait_cnt <= w_wait_nxt;
                        if (w_wait_nxt >= WAIT_LIMIT) begin
                            r_state   <= ST_TIMEOUT;
                            r_timeout <= 1'b1;
                        end else begin
                            r_state <= ST_MEM_WAIT;
                        end
                    end else begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= '0;
                    end
                end
                ST_TIMEOUT: begin
                    r_timeout <= 1'b1;
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    // A branch seen during a memory stall is not lost: E is held, so PCSrcE reappears on release
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (w_mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (w_lw_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (StallF && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign MemTimeout = r_timeout;
    assign StallCount = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, directed multi-cycle sequences and random stimulus vs a reference model.
module tb_pipe_hazard_ctrl;

    localparam int LIM   = 255;
    localparam int SCMAX = 65535;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]  ResultSrcE;
    logic        PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        MemTimeout;
    logic [15:0] StallCount;

    pipe_hazard_ctrl #(.TIMEOUT_LIMIT(LIM), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemTimeout(MemTimeout), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        string      name;
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic [1:0] rsrc;
        logic       pc, rwm, rww, req, rdy;
        logic [1:0] fa, fb;
        logic [6:0] ctl;
    } vec_t;

    vec_t vecs[$];

    // Reference model: consecutive memory-stall cycles, sticky timeout, saturating stall count
    bit m_wait, m_to;
    int m_wcnt, m_sc;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [6:0] ctl_now();
        return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 5'd0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 5'd0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit exp_mem();
        if (m_to) return 1'b1;
        if (m_wait) return !MemReadyM;
        return MemReqM && !MemReadyM;
    endfunction

    function automatic logic [6:0] exp_ctl();
        bit lw;
        lw = (ResultSrcE == 2'b01) && (RdE != 5'd0) && (RdE == Rs1D || RdE == Rs2D);
        if (exp_mem()) return 7'b1111001;
        if (PCSrcE)    return 7'b0000110;
        if (lw)        return 7'b1100010;
        return 7'b0000000;
    endfunction

    function automatic void model_reset();
        m_wait = 1'b0;
        m_to   = 1'b0;
        m_wcnt = 0;
        m_sc   = 0;
    endfunction

    function automatic void model_update();
        bit         mem;
        logic [6:0] c;
        mem = exp_mem();
        c   = exp_ctl();
        if (c[6] && m_sc < SCMAX) m_sc++;
        if (!m_to) begin
            if (mem) begin
                m_wcnt++;
                if (m_wcnt >= LIM) m_to = 1'b1;
                else m_wait = 1'b1;
            end else begin
                m_wait = 1'b0;
                m_wcnt = 0;
            end
        end
    endfunction

    task automatic compare_model(input string tag);
        check({tag, "_ctl"}, 32'(ctl_now()), 32'(exp_ctl()));
        check({tag, "_fa"}, 32'(ForwardAE), 32'(exp_fwd(Rs1E)));
        check({tag, "_fb"}, 32'(ForwardBE), 32'(exp_fwd(Rs2E)));
        check({tag, "_cnt"}, 32'(StallCount), 32'(m_sc));
        check({tag, "_to"}, 32'(MemTimeout), 32'(m_to));
    endtask

    // Called at a falling edge with inputs already set
    task automatic cycle(input bit chk, input string tag);
        #1;
        if (chk) compare_model(tag);
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_idle();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
        ResultSrcE = '0; PCSrcE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        MemReqM = 1'b0; MemReadyM = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v);
        Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e;
        RdE = v.rde; RdM = v.rdm; RdW = v.rdw; ResultSrcE = v.rsrc;
        PCSrcE = v.pc; RegWriteM = v.rwm; RegWriteW = v.rww;
        MemReqM = v.req; MemReadyM = v.rdy;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        model_reset();
        check({tag, "_rst_cnt"}, 32'(StallCount), 32'd0);
        check({tag, "_rst_to"}, 32'(MemTimeout), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        set_idle();
        reset = 1'b0;
        model_reset();

        vecs.push_back('{"idle",       5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 7'b0000000});
        vecs.push_back('{"fwd_m_pri",  5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 7'b0000000});
        vecs.push_back('{"fwd_w_rdm0", 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 7'b0000000});
        vecs.push_back('{"fwd_no_we",  5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 7'b0000000});
        vecs.push_back('{"fwd_b_w",    5'd0, 5'd0, 5'd0, 5'd9, 5'd0, 5'd9, 5'd9, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 7'b0000000});
        vecs.push_back('{"fwd_x0",     5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 7'b0000000});
        vecs.push_back('{"fwd_both_m", 5'd0, 5'd0, 5'd3, 5'd3, 5'd0, 5'd3, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 7'b0000000});
        vecs.push_back('{"lu_rs2",     5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 7'b1100010});
        vecs.push_back('{"lu_rs1",     5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 7'b1100010});
        vecs.push_back('{"no_load",    5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 7'b0000000});
        vecs.push_back('{"lu_x0",      5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 7'b0000000});
        vecs.push_back('{"lu_branch",  5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 7'b0000110});
        vecs.push_back('{"branch",     5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 7'b0000110});
        vecs.push_back('{"miss",       5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 7'b1111001});
        vecs.push_back('{"miss_br_lu", 5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 7'b1111001});
        vecs.push_back('{"hit",        5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 7'b0000000});
        vecs.push_back('{"fwd_stall",  5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 5'd4, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 7'b1111001});

        repeat (2) @(negedge clk);
        #1;
        check("rst_cnt", 32'(StallCount), 32'd0);
        check("rst_to", 32'(MemTimeout), 32'd0);

        // Reset held low keeps the FSM in RUN, so every vector sees the same state
        foreach (vecs[i]) begin
            apply_vec(vecs[i]);
            #1;
            check({vecs[i].name, "_ctl"}, 32'(ctl_now()), 32'(vecs[i].ctl));
            check({vecs[i].name, "_fa"}, 32'(ForwardAE), 32'(vecs[i].fa));
            check({vecs[i].name, "_fb"}, 32'(ForwardBE), 32'(vecs[i].fb));
            #1;
        end

        set_idle();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #1;
        check("idle_ctl", 32'(ctl_now()), 32'd0);
        cycle(1, "idle");

        // Load-use stalls exactly one cycle
        Rs2D = 5'd7; RdE = 5'd7; ResultSrcE = 2'b01;
        #1;
        check("lu_stall", 32'(ctl_now()), 32'(7'b1100010));
        cycle(1, "lu");
        set_idle();
        #1;
        check("lu_cnt", 32'(StallCount), 32'd1);
        check("lu_once", 32'(StallF), 32'd0);
        cycle(1, "lu_after");

        Rs2D = 5'd7; RdE = 5'd7; ResultSrcE = 2'b01; PCSrcE = 1'b1;
        #1;
        check("lu_br_ctl", 32'(ctl_now()), 32'(7'b0000110));
        cycle(1, "lu_br");

        // Three miss cycles with a pending branch; flush only on release
        set_idle();
        MemReqM = 1'b1; MemReadyM = 1'b0; PCSrcE = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("mw_stall", 32'(ctl_now()), 32'(7'b1111001));
            cycle(1, "mw");
        end
        MemReadyM = 1'b1;
        #1;
        check("mw_release", 32'(ctl_now()), 32'(7'b0000110));
        cycle(1, "mw_rel");
        set_idle();
        #1;
        check("mw_run", 32'(ctl_now()), 32'd0);
        cycle(1, "mw_run");

        // Reset in the middle of a wait returns to RUN
        MemReqM = 1'b1; MemReadyM = 1'b0;
        repeat (3) cycle(1, "mid");
        set_idle();
        do_reset("mid");
        #1;
        check("mid_run_ctl", 32'(ctl_now()), 32'd0);
        cycle(1, "mid_run");

        // Timeout after LIM consecutive wait cycles, sticky until reset
        MemReqM = 1'b1; MemReadyM = 1'b0;
        repeat (LIM) cycle(1, "to_wait");
        #1;
        check("timeout_flag", 32'(MemTimeout), 32'd1);
        MemReadyM = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("timeout_hold", 32'(StallF), 32'd1);
            cycle(1, "to_hold");
        end
        set_idle();
        do_reset("to");
        #1;
        check("post_to_ctl", 32'(ctl_now()), 32'd0);
        cycle(1, "post_to");

        for (int k = 0; k < 3000; k++) begin
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            ResultSrcE = 2'($urandom_range(0, 3));
            PCSrcE    = ($urandom_range(0, 3) == 0);
            RegWriteM = 1'($urandom_range(0, 1));
            RegWriteW = 1'($urandom_range(0, 1));
            MemReqM   = ($urandom_range(0, 2) == 0);
            MemReadyM = ($urandom_range(0, 2) != 0);
            cycle(1, "rnd");
        end

        // Stall counter saturation
        set_idle();
        do_reset("sat");
        MemReqM = 1'b1; MemReadyM = 1'b0;
        repeat (70000) cycle(0, "");
        #1;
        check("sat_cnt", 32'(StallCount), 32'hFFFF);
        cycle(1, "sat");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT_LIMIT, default 255, is the maximum number of memory wait cycles before timeout.
REQ-002 Parameter CNT_W, default 16, is the width of the stall-cycle counter.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 Rs1D, Rs2D  input  5 each  source registers of the instruction in D.
REQ-006 Rs1E, Rs2E, RdE  input  5 each  source and destination registers in E.
REQ-007 RdM, RdW  input  5 each  destination registers in M and W.
REQ-008 ResultSrcE  input  2  result select in E; 2'b01 marks a load.
REQ-009 PCSrcE  input  1  taken branch or jump resolved in E.
REQ-010 RegWriteM, RegWriteW  input  1 each  register write enables in M and W.
REQ-011 MemReqM, MemReadyM  input  1 each  data-memory access in M, and memory completion.
REQ-012 StallF, StallD, StallE, StallM  output  1 each  hold the F, D, E and M pipeline registers.
REQ-013 FlushD, FlushE, FlushW  output  1 each  clear the D, E and W pipeline registers to a bubble.
REQ-014 ForwardAE, ForwardBE  output  2 each  operand source: 00 register file, 01 W result, 10 M ALU result.
REQ-015 MemTimeout  output  1  sticky memory-timeout flag.
REQ-016 StallCount  output  CNT_W  number of cycles with StallF asserted.

Function
REQ-017 The FSM SHALL have three states: RUN, MEM_WAIT and TIMEOUT.
REQ-018 RUN: when MemReqM=1 and MemReadyM=0, the block SHALL assert memStall combinationally in that cycle and go to MEM_WAIT.
REQ-019 MEM_WAIT: the block SHALL assert memStall while MemReadyM=0 and increment the wait counter each cycle.
REQ-020 MEM_WAIT: on MemReadyM=1 the block SHALL deassert memStall in that same cycle, clear the wait counter and go to RUN.
REQ-021 The block SHALL go to TIMEOUT when the wait counter reaches TIMEOUT_LIMIT with MemReadyM=0.
REQ-022 In TIMEOUT the block SHALL hold memStall=1 and MemTimeout=1 until reset.
REQ-023 memStall SHALL assert StallF, StallD, StallE, StallM and FlushW, and deassert all other flushes.
REQ-024 The block SHALL compute lwStall = (ResultSrcE==2'b01) and RdE!=0 and (RdE==Rs1D or RdE==Rs2D).
REQ-025 Without memStall, PCSrcE SHALL assert FlushD and FlushE and SHALL suppress lwStall, since the D instruction is discarded.
REQ-026 Without memStall or PCSrcE, lwStall SHALL assert StallF, StallD and FlushE for exactly one cycle.
REQ-027 When memStall and PCSrcE coincide, the flush SHALL be deferred to the first non-stalled cycle; E is frozen, so PCSrcE is still present then.
REQ-028 ForwardAE SHALL be 10 if RegWriteM, RdM!=0 and RdM==Rs1E; else 01 if RegWriteW, RdW!=0 and RdW==Rs1E; else 00. ForwardBE SHALL follow the same rule using Rs2E.
REQ-029 Forwarding outputs SHALL be combinational and independent of the stall state.
REQ-030 StallCount SHALL increment on each clock with StallF=1 and saturate at all-ones.

Reset
REQ-031 reset low SHALL force the state to RUN, clear the wait counter, StallCount and MemTimeout, and is effective mid-wait.
REQ-032 With all inputs at 0 after reset, all stall and flush outputs SHALL be 0 and ForwardAE=ForwardBE=00.

Structure
REQ-033 The shared package SHALL hold the FSM state enum, the forward-select encodings FWD_RF/FWD_W/FWD_M, the load encoding RES_LOAD=2'b01, and the TIMEOUT_LIMIT default.
REQ-034 Forwarding SHALL be implemented as one sub-module, hazard_fwd_unit, instantiated once per operand.

Verification
REQ-035 Scenario: RdM=5, RegWriteM=1, Rs1E=5, and RdW=5, RegWriteW=1 -> ForwardAE=10; with RdM=0 -> ForwardAE=01.
REQ-036 Scenario: ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle, then StallCount=1.
REQ-037 Scenario: the load-use case of REQ-036 plus PCSrcE=1 -> FlushD=FlushE=1 and StallF=0.
REQ-038 Scenario: MemReqM=1 with MemReadyM low for 3 cycles -> four stalls and FlushW=1 for 3 cycles, then RUN; with PCSrcE=1 throughout, FlushD/FlushE assert in the release cycle only.
REQ-039 Scenario: MemReadyM held low for 255 cycles -> MemTimeout=1 and stalls persist; reset low -> RUN, StallCount=0, MemTimeout=0.
REQ-040 Scenario: force 70000 stall cycles -> StallCount=16'hFFFF.
